// File: rtl/nubus_mst_watchdog.sv
// NuBus master transaction watchdog.
// Tracks one master transaction from START to its ACK. It declares a timeout when
// no ACK arrives in time, and paces try-again-later retries with a backoff
// interval. It gives up once the retry budget is spent. All state changes on
// the falling edge of the NuBus clock.
module nubus_mst_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned RETRY_MAX      = 8,
  parameter int unsigned BACKOFF_CYCLES = 4
) (
  input  logic       nub_clkn,
  input  logic       nub_resetn,
  input  logic       mst_start,
  input  logic       mst_cancel,
  input  logic       nub_ackn,
  input  logic [1:0] nub_status,
  output logic       mst_busy,
  output logic       mst_done,
  output logic       mst_timeout,
  output logic       mst_retry,
  output logic       mst_giveup,
  output logic [3:0] mst_retries
);

  // Shared NuBus transaction status codes, qualified by ACK
  localparam logic [1:0] TMN_COMPLETE        = 2'b00;
  localparam logic [1:0] TMN_ERROR           = 2'b01;
  localparam logic [1:0] TMN_TIMEOUT_ERROR   = 2'b10;
  localparam logic [1:0] TMN_TRY_AGAIN_LATER = 2'b11;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_BACKOFF = 2'd2;

  // Counter values seen on the edge that completes the interval
  localparam logic [11:0] L_WAIT_LAST = 12'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  L_BACK_LAST = 8'(BACKOFF_CYCLES - 1);
  localparam logic [3:0]  L_RETRY_MAX = 4'(RETRY_MAX);

  logic [1:0]  r_state;
  logic [11:0] r_wait_cnt;
  logic [7:0]  r_back_cnt;
  logic [3:0]  r_retries;
  logic        r_busy, r_done, r_timeout, r_retry, r_giveup;

  logic [1:0]  w_state_nxt;
  logic [11:0] w_wait_nxt;
  logic [7:0]  w_back_nxt;
  logic [3:0]  w_retries_nxt;
  logic        w_busy_nxt, w_done_nxt, w_timeout_nxt, w_retry_nxt, w_giveup_nxt;

  // Next-state decode; cancel outranks ACK, and ACK outranks the wait timeout
  always_comb begin
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait_cnt;
    w_back_nxt    = r_back_cnt;
    w_retries_nxt = r_retries;
    w_done_nxt    = 1'b0;
    w_timeout_nxt = 1'b0;
    w_retry_nxt   = 1'b0;
    w_giveup_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mst_start) begin
          w_state_nxt   = ST_WAIT;
          w_wait_nxt    = '0;
          w_retries_nxt = '0;
        end
      end
      ST_WAIT: begin
        if (mst_cancel) begin
          w_state_nxt = ST_IDLE;
          w_wait_nxt  = '0;
        end else if (!nub_ackn) begin
          w_wait_nxt = '0;
          case (nub_status)
            TMN_COMPLETE, TMN_ERROR: begin
              w_done_nxt  = 1'b1;
              w_state_nxt = ST_IDLE;
            end
            TMN_TIMEOUT_ERROR: begin
              w_timeout_nxt = 1'b1;
              w_state_nxt   = ST_IDLE;
            end
            default: begin
              if (r_retries == L_RETRY_MAX) begin
                w_giveup_nxt = 1'b1;
                w_state_nxt  = ST_IDLE;
              end else begin
                w_retries_nxt = r_retries + 4'd1;
                w_back_nxt    = '0;
                w_state_nxt   = ST_BACKOFF;
              end
            end
          endcase
        end else if (r_wait_cnt == L_WAIT_LAST) begin
          w_timeout_nxt = 1'b1;
          w_wait_nxt    = '0;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_wait_nxt = r_wait_cnt + 12'd1;
        end
      end
      ST_BACKOFF: begin
        if (mst_cancel) begin
          w_state_nxt = ST_IDLE;
          w_back_nxt  = '0;
        end else if (r_back_cnt == L_BACK_LAST) begin
          w_retry_nxt = 1'b1;
          w_back_nxt  = '0;
          w_wait_nxt  = '0;
          w_state_nxt = ST_WAIT;
        end else begin
          w_back_nxt = r_back_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_wait_nxt  = '0;
        w_back_nxt  = '0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State, counters and registered outputs; reset drops everything at once
  always_ff @(negedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_back_cnt <= '0;
      r_retries  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_retry    <= 1'b0;
      r_giveup   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_back_cnt <= w_back_nxt;
      r_retries  <= w_retries_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_timeout  <= w_timeout_nxt;
      r_retry    <= w_retry_nxt;
      r_giveup   <= w_giveup_nxt;
    end
  end

  assign mst_busy    = r_busy;
  assign mst_done    = r_done;
  assign mst_timeout = r_timeout;
  assign mst_retry   = r_retry;
  assign mst_giveup  = r_giveup;
  assign mst_retries = r_retries;

endmodule
